// File: rtl/arb_pkg.sv
// Shared types and width defaults for the unified-memory arbiter.
package arb_pkg;

  localparam int AW_DEF = 14;
  localparam int DW_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle for mem_arbiter.
// master: the arbiter's view (drives acks and the memory command).
// slave:  the surrounding caches and memory (drive requests and completion).
interface mem_arbiter_if #(
  parameter int AW = arb_pkg::AW_DEF,
  parameter int DW = arb_pkg::DW_DEF
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          m_re;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_rdy;
  logic [DW-1:0] m_rdata;

  logic [1:0]    owner;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdy, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_re, m_we, m_addr, m_wdata, owner
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdy, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_re, m_we, m_addr, m_wdata, owner
  );
endinterface

// File: rtl/arb_pick.sv
// Combinational winner select between the I-side and D-side requests.
// ARB_RR_EN defined: a tie goes to the side that did not win last (rr_last: 0=I, 1=D).
// ARB_RR_EN undefined: a tie always goes to D; rr_last is ignored.
module arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic rr_last,
  output logic grant,
  output logic pick_d
);

`ifdef ARB_RR_EN
  // Lone requester wins; on a tie alternate away from the last winner.
  always_comb begin
    grant  = i_req | d_req;
    pick_d = d_req;
    if (i_req && d_req) pick_d = ~rr_last;
  end
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last;

  // Lone requester wins; D (older instruction) wins any tie.
  always_comb begin
    grant  = i_req | d_req;
    pick_d = d_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter between the I-side fetch-miss path and the
// D-side miss/writeback path. One access at a time; the command is held until
// m_rdy, then a registered one-cycle ack goes to the owner.
// Optional macro ARB_RR_EN: round-robin tie break instead of fixed D priority.
//
// state | meaning
// IDLE  | no access; arbitrate and latch the winner's command
// BUSY  | command held on the memory port, waiting for m_rdy
// RESP  | command dropped, ack pulsed to the owner
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus
);

  state_t        state_q, state_d;
  owner_t        owner_q;
  logic          grant, pick_d, done;
  logic          rr_last;
  logic          m_re_q, m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] rd_q;
  logic          i_ack_q, d_ack_q;

  arb_pick u_pick (
    .i_req  (bus.i_req),
    .d_req  (bus.d_req),
    .rr_last(rr_last),
    .grant  (grant),
    .pick_d (pick_d)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; 'start' of an access only from IDLE, completion only from BUSY,
  // so m_rdy outside BUSY never has an effect.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (grant) state_d = BUSY;
      BUSY: if (bus.m_rdy) begin
        done    = 1'b1;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command, owner, ack and shared read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_re_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      owner_q   <= OWN_NONE;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      if (state_q == IDLE && grant) begin
        m_re_q    <= ~(pick_d & bus.d_we);
        m_we_q    <= pick_d & bus.d_we;
        m_addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
        m_wdata_q <= pick_d ? bus.d_wdata : '0;
        owner_q   <= pick_d ? OWN_D : OWN_I;
      end
      if (done) begin
        m_re_q  <= 1'b0;
        m_we_q  <= 1'b0;
        i_ack_q <= (owner_q == OWN_I);
        d_ack_q <= (owner_q == OWN_D);
        if (m_re_q) rd_q <= bus.m_rdata;
      end
      if (state_q == RESP) owner_q <= OWN_NONE;
    end
  end

`ifdef ARB_RR_EN
  // Remember which side won the most recent grant (0=I, 1=D).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rr_last <= 1'b0;
    else if (state_q == IDLE && grant) rr_last <= pick_d;
  end
`else
  assign rr_last = 1'b0;
`endif

  assign bus.m_re    = m_re_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.owner   = owner_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_rdata = rd_q;
  assign bus.d_rdata = rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single/tie accesses plus
// hand-written reset, spurious-completion and back-to-back sequences.
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int AW = 14;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Memory model: completes in the lat-th command cycle.
  int            lat = 1;
  int            mcnt;
  logic [DW-1:0] mem_rdata = '0;
  logic          spur_rdy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    mcnt <= 0;
    else if (bus.m_re | bus.m_we)  mcnt <= mcnt + 1;
    else                           mcnt <= 0;
  end

  assign bus.m_rdy   = ((bus.m_re | bus.m_we) && (mcnt == lat - 1)) || spur_rdy;
  assign bus.m_rdata = mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Observations gathered by run().
  int            n_acc, n_ack, both_ack;
  logic [1:0]    acc_own  [8];
  logic          acc_re   [8];
  logic          acc_we   [8];
  logic [AW-1:0] acc_addr [8];
  logic [DW-1:0] acc_wd   [8];
  int            acc_start[8];
  int            acc_last [8];
  bit            acc_bad  [8];
  logic [1:0]    ack_side [8];
  int            ack_cyc  [8];
  logic [DW-1:0] ack_data [8];

  // Act as registered requesters: each side issues cnt requests, drops req when
  // it sees ack and re-raises no earlier than the edge after the IDLE cycle.
  // Cycle k=1 is the first cycle after the edge that sees the requests.
  task automatic run(input int i_cnt, input int d_cnt, input int budget);
    int i_left = i_cnt;
    int d_left = d_cnt;
    int i_rearm = -1;
    int d_rearm = -1;
    bit in_cmd = 0;
    bit fin = 0;
    n_acc = 0; n_ack = 0; both_ack = 0;
    for (int j = 0; j < 8; j++) begin
      acc_own[j] = '0; acc_re[j] = 0; acc_we[j] = 0; acc_addr[j] = '0; acc_wd[j] = '0;
      acc_start[j] = 0; acc_last[j] = 0; acc_bad[j] = 0;
      ack_side[j] = '0; ack_cyc[j] = 0; ack_data[j] = '0;
    end
    bus.i_req = (i_cnt > 0);
    bus.d_req = (d_cnt > 0);
    for (int k = 1; k <= budget && !fin; k++) begin
      @(negedge clk);
      if (bus.m_re | bus.m_we) begin
        if (!in_cmd && n_acc < 8) begin
          acc_own[n_acc]   = bus.owner;
          acc_re[n_acc]    = bus.m_re;
          acc_we[n_acc]    = bus.m_we;
          acc_addr[n_acc]  = bus.m_addr;
          acc_wd[n_acc]    = bus.m_wdata;
          acc_start[n_acc] = k;
          acc_last[n_acc]  = k;
          n_acc++;
        end else if (n_acc > 0) begin
          if (bus.m_addr !== acc_addr[n_acc-1] || bus.m_wdata !== acc_wd[n_acc-1] ||
              bus.m_re !== acc_re[n_acc-1] || bus.m_we !== acc_we[n_acc-1] ||
              bus.owner !== acc_own[n_acc-1])
            acc_bad[n_acc-1] = 1;
          acc_last[n_acc-1] = k;
        end
        in_cmd = 1;
      end else begin
        in_cmd = 0;
      end
      if (bus.i_ack && bus.d_ack) both_ack++;
      if (bus.i_ack) begin
        if (n_ack < 8) begin
          ack_side[n_ack] = 2'b01; ack_cyc[n_ack] = k; ack_data[n_ack] = bus.i_rdata; n_ack++;
        end
        bus.i_req = 1'b0;
        i_left--;
        if (i_left > 0) i_rearm = k + 2;
      end
      if (bus.d_ack) begin
        if (n_ack < 8) begin
          ack_side[n_ack] = 2'b10; ack_cyc[n_ack] = k; ack_data[n_ack] = bus.d_rdata; n_ack++;
        end
        bus.d_req = 1'b0;
        d_left--;
        if (d_left > 0) d_rearm = k + 2;
      end
      if (k == i_rearm) bus.i_req = 1'b1;
      if (k == d_rearm) bus.d_req = 1'b1;
      if (i_left <= 0 && d_left <= 0 && bus.owner == 2'b00 && !bus.i_ack && !bus.d_ack)
        fin = 1;
    end
    chk("run_completed", 64'(fin), 64'd1);
  endtask

  typedef struct {
    logic          ireq, dreq, dwe;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] wdata, rdata;
    int            lat;
    logic [1:0]    own0;
    logic          re0, we0;
    logic [AW-1:0] addr0;
    int            ack0;
    logic [DW-1:0] rd0;
    logic [1:0]    own1;
    int            ack1;
    logic [DW-1:0] rd1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nexp;
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

    // ireq dreq dwe iaddr daddr wdata rdata lat | own0 re0 we0 addr0 ack0 rd0 | own1 ack1 rd1
    vecs[0] = '{1, 0, 0, 14'h0012, 14'h0000, 64'h0, 64'hDEAD_BEEF_0000_1234, 4,
                2'b01, 1, 0, 14'h0012, 5, 64'hDEAD_BEEF_0000_1234, 2'b00, 0, 64'h0};
    vecs[1] = '{0, 1, 1, 14'h0000, 14'h3FFF, 64'h0123_4567_89AB_CDEF, 64'h5555_5555_5555_5555, 3,
                2'b10, 0, 1, 14'h3FFF, 4, 64'hDEAD_BEEF_0000_1234, 2'b00, 0, 64'h0};
    vecs[2] = '{0, 1, 0, 14'h0000, 14'h0100, 64'h0, 64'hA5A5_0000_FFFF_0001, 1,
                2'b10, 1, 0, 14'h0100, 2, 64'hA5A5_0000_FFFF_0001, 2'b00, 0, 64'h0};
`ifdef ARB_RR_EN
    vecs[3] = '{1, 1, 0, 14'h0001, 14'h0002, 64'h0, 64'h1111_2222_3333_4444, 2,
                2'b01, 1, 0, 14'h0001, 3, 64'h1111_2222_3333_4444, 2'b10, 7, 64'h1111_2222_3333_4444};
    vecs[4] = '{1, 1, 1, 14'h0AAA, 14'h1555, 64'hFEDC_BA98_7654_3210, 64'h7777_8888_9999_0000, 1,
                2'b01, 1, 0, 14'h0AAA, 2, 64'h7777_8888_9999_0000, 2'b10, 5, 64'h7777_8888_9999_0000};
`else
    vecs[3] = '{1, 1, 0, 14'h0001, 14'h0002, 64'h0, 64'h1111_2222_3333_4444, 2,
                2'b10, 1, 0, 14'h0002, 3, 64'h1111_2222_3333_4444, 2'b01, 7, 64'h1111_2222_3333_4444};
    vecs[4] = '{1, 1, 1, 14'h0AAA, 14'h1555, 64'hFEDC_BA98_7654_3210, 64'h7777_8888_9999_0000, 1,
                2'b10, 0, 1, 14'h1555, 2, 64'h1111_2222_3333_4444, 2'b01, 5, 64'h7777_8888_9999_0000};
`endif
    vecs[5] = '{0, 1, 0, 14'h0000, 14'h2000, 64'h0, 64'h0F0F_0F0F_1234_5678, 6,
                2'b10, 1, 0, 14'h2000, 7, 64'h0F0F_0F0F_1234_5678, 2'b00, 0, 64'h0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_m_re",    64'(bus.m_re),    64'd0);
    chk("rst_m_we",    64'(bus.m_we),    64'd0);
    chk("rst_m_addr",  64'(bus.m_addr),  64'd0);
    chk("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
    chk("rst_acks",    64'({bus.i_ack, bus.d_ack}), 64'd0);
    chk("rst_owner",   64'(bus.owner),   64'd0);
    chk("rst_rdata",   64'(bus.i_rdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_owner", 64'(bus.owner), 64'd0);

    // Table-driven accesses.
    for (int i = 0; i < 6; i++) begin
      bus.i_addr  = vecs[i].iaddr;
      bus.d_addr  = vecs[i].daddr;
      bus.d_we    = vecs[i].dwe;
      bus.d_wdata = vecs[i].wdata;
      lat         = vecs[i].lat;
      mem_rdata   = vecs[i].rdata;
      run(vecs[i].ireq ? 1 : 0, vecs[i].dreq ? 1 : 0, 60);
      nexp = (vecs[i].own1 != 2'b00) ? 2 : 1;
      chk($sformatf("v%0d n_acc", i),  64'(n_acc),       64'(nexp));
      chk($sformatf("v%0d n_ack", i),  64'(n_ack),       64'(nexp));
      chk($sformatf("v%0d both_ack", i), 64'(both_ack),  64'd0);
      chk($sformatf("v%0d own0", i),   64'(acc_own[0]),  64'(vecs[i].own0));
      chk($sformatf("v%0d re0", i),    64'(acc_re[0]),   64'(vecs[i].re0));
      chk($sformatf("v%0d we0", i),    64'(acc_we[0]),   64'(vecs[i].we0));
      chk($sformatf("v%0d addr0", i),  64'(acc_addr[0]), 64'(vecs[i].addr0));
      if (vecs[i].we0) chk($sformatf("v%0d wdata0", i), acc_wd[0], vecs[i].wdata);
      chk($sformatf("v%0d hold0", i),  64'(acc_bad[0]),  64'd0);
      chk($sformatf("v%0d len0", i),   64'(acc_last[0] - acc_start[0] + 1), 64'(vecs[i].lat));
      chk($sformatf("v%0d ack_side0", i), 64'(ack_side[0]), 64'(vecs[i].own0));
      chk($sformatf("v%0d ack_cyc0", i),  64'(ack_cyc[0]),  64'(vecs[i].ack0));
      chk($sformatf("v%0d rdata0", i),    ack_data[0],      vecs[i].rd0);
      if (nexp == 2) begin
        chk($sformatf("v%0d own1", i),      64'(acc_own[1]),  64'(vecs[i].own1));
        chk($sformatf("v%0d ack_side1", i), 64'(ack_side[1]), 64'(vecs[i].own1));
        chk($sformatf("v%0d ack_cyc1", i),  64'(ack_cyc[1]),  64'(vecs[i].ack1));
        chk($sformatf("v%0d rdata1", i),    ack_data[1],      vecs[i].rd1);
        chk($sformatf("v%0d idle_gap", i),  64'(acc_start[1] - acc_last[0] - 1), 64'd2);
        chk($sformatf("v%0d hold1", i),     64'(acc_bad[1]),  64'd0);
      end
    end

    // Spurious completion in IDLE.
    bus.i_req = 0; bus.d_req = 0;
    spur_rdy = 1'b1;
    @(negedge clk);
    spur_rdy = 1'b0;
    chk("spur_acks",  64'({bus.i_ack, bus.d_ack}), 64'd0);
    chk("spur_owner", 64'(bus.owner), 64'd0);
    chk("spur_cmd",   64'({bus.m_re, bus.m_we}), 64'd0);
    @(negedge clk);
    chk("spur_acks2", 64'({bus.i_ack, bus.d_ack}), 64'd0);
    bus.i_addr = 14'h0033; lat = 2; mem_rdata = 64'hCAFE_F00D_0000_0033;
    run(1, 0, 40);
    chk("spur_follow_ack_cyc", 64'(ack_cyc[0]), 64'd3);
    chk("spur_follow_rdata",   ack_data[0], 64'hCAFE_F00D_0000_0033);

    // Reset in the second BUSY cycle, then re-serve the held request.
    bus.i_addr = 14'h0ABC; lat = 5; mem_rdata = 64'h0BAD_C0DE_0000_0ABC;
    bus.i_req = 1'b1;
    @(negedge clk);
    chk("mid_busy1_m_re", 64'(bus.m_re), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_re",  64'(bus.m_re),  64'd0);
    chk("mid_rst_owner", 64'(bus.owner), 64'd0);
    chk("mid_rst_acks",  64'({bus.i_ack, bus.d_ack}), 64'd0);
    chk("mid_rst_rdata", 64'(bus.i_rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 0, 40);
    chk("reserve_n_acc",   64'(n_acc),       64'd1);
    chk("reserve_addr",    64'(acc_addr[0]), 64'h0ABC);
    chk("reserve_ack_cyc", 64'(ack_cyc[0]),  64'd6);
    chk("reserve_side",    64'(ack_side[0]), 64'h1);
    chk("reserve_rdata",   ack_data[0],      64'h0BAD_C0DE_0000_0ABC);

    // Continuous requests from both sides: grant order D, I, D, I.
    bus.i_addr = 14'h0111; bus.d_addr = 14'h0222; bus.d_we = 1'b0;
    lat = 1; mem_rdata = 64'h2468_ACE0_1357_9BDF;
    run(2, 2, 80);
    chk("cont_n_acc", 64'(n_acc), 64'd4);
    chk("cont_own0",  64'(acc_own[0]), 64'h2);
    chk("cont_own1",  64'(acc_own[1]), 64'h1);
    chk("cont_own2",  64'(acc_own[2]), 64'h2);
    chk("cont_own3",  64'(acc_own[3]), 64'h1);
    chk("cont_addr1", 64'(acc_addr[1]), 64'h0111);
    chk("cont_addr2", 64'(acc_addr[2]), 64'h0222);
    chk("cont_both",  64'(both_ack), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single-ported unified main memory between the instruction-fetch miss path (read-only) and the data-memory miss/writeback path (read or write) of the pipelined cpu. It accepts line-wide requests from both sides and grants one at a time. It holds the memory command stable until the memory reports completion, then returns a registered one-cycle acknowledge to the owning requester. It sits below the I-side and D-side cache controllers and is the only master of the memory port.

## Interface
- AW, 14, line address width
- DW, 64, line data width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_req  in  1  I-side read request, level, held until i_ack
- i_addr  in  AW  I-side line address, stable while i_req
- i_ack  out  1  one-cycle completion pulse to I-side
- i_rdata  out  DW  I-side read line, valid during i_ack
- d_req  in  1  D-side request, level, held until d_ack
- d_we  in  1  D-side write (1) / read (0), stable while d_req
- d_addr  in  AW  D-side line address
- d_wdata  in  DW  D-side write line
- d_ack  out  1  one-cycle completion pulse to D-side
- d_rdata  out  DW  D-side read line, valid during d_ack on reads
- m_re, m_we  out  1  memory command, held for the whole access
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdy  in  1  memory completion pulse; m_rdata valid the same cycle
- m_rdata  in  DW  memory read data
- owner  out  2  debug: 00 none, 01 I, 10 D

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if either request is high, pick a winner, latch its address, data and direction into command registers, set owner, and go to BUSY. Otherwise stay in IDLE. m_rdy seen in IDLE is ignored.
- Pick rule: a lone requester always wins. When both requests are high, D wins (the older pipeline instruction), unless ARB_RR_EN is defined.
- BUSY: m_re or m_we is asserted and m_addr/m_wdata are held constant. The requester's inputs are no longer sampled.
  - On m_rdy, a read captures m_rdata into a shared read register, and the block goes to RESP.
  - A write does not update the read register.
- RESP: deassert m_re/m_we and pulse the owner's ack (i_ack or d_ack, never both), then go to IDLE. The other requester's pending request waits and is considered in that IDLE cycle.
- Requester rule: req is a registered signal cleared on the same edge that samples ack=1. The arbiter therefore never double-serves one request.
- i_rdata and d_rdata both read the shared read register. Each is meaningful only during its ack.
- I-side requests always issue m_re. I-side writes do not exist.

## Timing
- Reset values: state IDLE; every output 0, including m_re, m_we, m_addr, m_wdata, i_ack, d_ack, owner, and the read register; rr_last = I.
- Request high in IDLE at edge E: m_re/m_we high from E+1.
- If m_rdy arrives in the Nth command cycle, ack is high in cycle N+1 after E, and the block is back in IDLE one cycle later.
- With a memory latency of N, request-to-ack is N+1 cycles. The dead cycle between back-to-back grants is 2 cycles (RESP plus IDLE).
- m_rdy is honoured in the first BUSY cycle as well, so the minimum N is 1.
- Reset mid-access: the access is abandoned and all outputs drop asynchronously. The memory shares rst_n.
- Simultaneous m_rdy and a new request: no effect until IDLE.

## Configuration
- ARB_RR_EN defined:
  - Adds a 1-bit rr_last register, set to the granted side on each grant.
  - On a tie, the side not equal to rr_last wins.
  - Reset value I, so the first tie goes to D.
- Not defined: fixed D priority, no rr_last register. I-side starvation is possible under continuous D traffic.

## Structure
- Package arb_pkg: state enum (IDLE, BUSY, RESP), owner encoding (OWN_NONE, OWN_I, OWN_D), and defaults for AW and DW.
- Sub-module arb_pick: combinational winner select from i_req, d_req and rr_last. Under ARB_RR_EN, rr_last is used; otherwise it is tied off.
- The FSM, command registers and read register live in mem_arbiter.

## Test plan
- I read alone:
  - Stimulus: i_req, i_addr=0x0012, memory latency 4, m_rdata=0xDEAD_BEEF_0000_1234.
  - Response: m_re high for 4 cycles, i_ack in cycle 5 with that data, d_ack stays 0, owner 01 during the access.
- D write:
  - Stimulus: d_we=1, d_addr=0x3FFF, d_wdata=0x0123_4567_89AB_CDEF.
  - Response: m_we held with that address and data until m_rdy, d_ack pulses once, and the read register keeps its prior value.
- Tie, fixed priority:
  - Stimulus: i_req and d_req raised on the same cycle.
  - Response: D served first; I served starting in the IDLE cycle after d_ack; there are exactly 2 idle memory cycles between the accesses.
- Tie with ARB_RR_EN:
  - Stimulus: continuous i_req and d_req, 4 accesses.
  - Response: grant order D, I, D, I.
- Reset mid-access:
  - Stimulus: rst_n low in the 2nd BUSY cycle.
  - Response: m_re, owner and acks go to 0 immediately; after release, the held request is re-served from scratch.
- Spurious completion:
  - Stimulus: m_rdy pulsed in IDLE with no request.
  - Response: no ack, state stays IDLE.
